// File: rtl/code_dumper_pkg.sv
// ============================================================================
// Module      : code_dumper_pkg
// Description : FSM state type and byte constants for the code memory dumper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package code_dumper_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    CHECK     = 3'd2,
    SEND      = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_IDLE = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [7:0] END_BYTE = 8'h00;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;

endpackage

`default_nettype wire

// File: rtl/code_dumper.sv
// ============================================================================
// Module      : code_dumper
// Description : Streams code memory bytes to a UART until a 0x00 byte or the
//               last address; DUMPER_CRLF_EN appends a CR/LF trailer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module code_dumper
  import code_dumper_pkg::*;
#(
  parameter int addrSize_code = 9
) (
  input  logic                     sysClk,
  input  logic                     reset,
  input  logic                     start,
  output logic [addrSize_code-1:0] addrCode,
  input  logic [7:0]               codeIn,
  input  logic                     tx_ready,
  output logic [7:0]               data_tx,
  output logic                     start_transmit,
  output logic                     done
);

  localparam logic [addrSize_code-1:0] ADDR_LAST = '1;

  state_t                   r_state;
  state_t                   w_next;
  logic [addrSize_code-1:0] r_addr;
  logic [addrSize_code-1:0] w_addrNext;
  logic [7:0]               r_data;
  logic [7:0]               w_dataNext;
  logic                     w_startTx;
  logic                     w_term;
`ifdef DUMPER_CRLF_EN
  logic                     r_trailer;
  logic                     w_trailerNext;
`endif

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_data    <= 8'h00;
`ifdef DUMPER_CRLF_EN
      r_trailer <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
      r_addr    <= w_addrNext;
      r_data    <= w_dataNext;
`ifdef DUMPER_CRLF_EN
      r_trailer <= w_trailerNext;
`endif
    end
  end

  always_comb begin
    w_next     = r_state;
    w_addrNext = r_addr;
    w_dataNext = r_data;
    w_startTx  = 1'b0;
    w_term     = 1'b0;
`ifdef DUMPER_CRLF_EN
    w_trailerNext = r_trailer;
`endif
    case (r_state)
      IDLE: begin
        w_addrNext = '0;
`ifdef DUMPER_CRLF_EN
        w_trailerNext = 1'b0;
`endif
        if (start) w_next = FETCH;
      end
      FETCH: w_next = CHECK;
      CHECK: begin
        if (codeIn == END_BYTE) begin
          w_term = 1'b1;
        end else begin
          w_dataNext = codeIn;
          w_next     = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          w_startTx = 1'b1;
          w_next    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!tx_ready) w_next = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (tx_ready) begin
`ifdef DUMPER_CRLF_EN
          // Trailer bytes reuse the send path; CR is always followed by LF.
          if (r_trailer) begin
            if (r_data == CR) begin
              w_dataNext = LF;
              w_next     = SEND;
            end else begin
              w_next = DONE;
            end
          end else
`endif
          if (r_addr == ADDR_LAST) begin
            w_term = 1'b1;
          end else begin
            w_addrNext = r_addr + 1'b1;
            w_next     = FETCH;
          end
        end
      end
      DONE: begin
        if (!start) begin
          w_next     = IDLE;
          w_addrNext = '0;
        end
      end
      default: w_next = IDLE;
    endcase

    if (w_term) begin
`ifdef DUMPER_CRLF_EN
      w_dataNext    = CR;
      w_trailerNext = 1'b1;
      w_next        = SEND;
`else
      w_next = DONE;
`endif
    end
  end

  assign addrCode       = r_addr;
  assign data_tx        = r_data;
  assign start_transmit = w_startTx;
  assign done           = (r_state == DONE);

endmodule

`default_nettype wire
